neuron_state_mem: RTL and testbench

//  Parametrised neuron-state store: DEPTH words of DATA_W bits, one word per neuron.
//  - Read and write ports share one clock.
//  - A built-in init sweep writes init_value to every word after reset or on request.
//  - Sits between the neuron update pipeline (reads state, writes updated state) and the controller (triggers init).

---
 rtl/neuron_mem_pkg.sv | 17 +
 rtl/neuron_sdp_ram.sv | 29 ++
 rtl/neuron_state_mem.sv | 161 ++++++++++++++++
 tb/tb_neuron_state_mem.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mem_pkg.sv
// Shared types for the neuron state memory: controller FSM states and the
// source select for the registered read-data path.
package neuron_mem_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        SWEEP = 2'd1,
        IDLE  = 2'd2
    } nsm_state_t;

    typedef enum logic [1:0] {
        RSEL_ZERO = 2'd0,
        RSEL_RAM  = 2'd1,
        RSEL_BYP  = 2'd2
    } nsm_rsel_t;

endpackage

// File: rtl/neuron_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port on a shared clock.
// Read-first with a registered output so it maps onto block RAM.
module neuron_sdp_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset; the owner guarantees it is swept before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/neuron_state_mem.sv
// Neuron state store: one word per neuron, swept to init_value after reset or init_start.
// Optional macro BYPASS_EN: same-cycle read and write of one address returns the new data.
module neuron_state_mem
    import neuron_mem_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_start,
    input  logic [DATA_W-1:0] init_value,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              init_done,
    output logic              access_drop
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    nsm_state_t        state;
    nsm_rsel_t         rsel;
    logic [ADDR_W-1:0] sweep_addr;
    logic [DATA_W-1:0] init_reg;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] byp_q;
    logic              byp_hit;
    logic              idle;
    logic              rd_ok;
    logic              wr_ok;
    logic              rd_acc;
    logic              wr_acc;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign idle   = (state == IDLE);
    assign busy   = !idle;
    assign rd_ok  = ({1'b0, rd_addr} < DEPTH_EXT);
    assign wr_ok  = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_acc = idle && rd_en;
    assign wr_acc = idle && wr_en && wr_ok;

    // The sweep owns the write port whenever it runs; user writes only land in IDLE.
    assign ram_we    = (state == SWEEP) || wr_acc;
    assign ram_waddr = (state == SWEEP) ? sweep_addr : wr_addr;
    assign ram_wdata = (state == SWEEP) ? init_reg : wr_data;
    assign ram_re    = rd_acc && rd_ok;

    neuron_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // Init controller: capture the value once in START so later changes to
    // init_value cannot corrupt a sweep already under way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= START;
            sweep_addr <= '0;
            init_reg   <= '0;
            init_done  <= 1'b0;
        end else begin
            init_done <= 1'b0;
            case (state)
                START: begin
                    init_reg   <= init_value;
                    sweep_addr <= '0;
                    state      <= init_start ? START : SWEEP;
                end
                SWEEP: begin
                    if (init_start) begin
                        state      <= START;
                        sweep_addr <= '0;
                    end else if (sweep_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        sweep_addr <= '0;
                        init_done  <= 1'b1;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                IDLE: begin
                    if (init_start) begin
                        state      <= START;
                        sweep_addr <= '0;
                    end
                end
                default: begin
                    state      <= START;
                    sweep_addr <= '0;
                end
            endcase
        end
    end

`ifdef BYPASS_EN
    assign byp_hit = wr_en && (wr_addr == rd_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_q <= '0;
        end else if (rd_acc && byp_hit) begin
            byp_q <= wr_data;
        end
    end
`else
    assign byp_hit = 1'b0;
    assign byp_q   = '0;
`endif

    // rsel remembers where the last accepted read came from, so rd_data holds
    // between reads and is zero out of reset without resetting the RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid    <= 1'b0;
            access_drop <= 1'b0;
            rsel        <= RSEL_ZERO;
        end else begin
            rd_valid    <= rd_acc;
            access_drop <= busy && (rd_en || wr_en);
            if (rd_acc) begin
                if (!rd_ok) begin
                    rsel <= RSEL_ZERO;
                end else if (byp_hit) begin
                    rsel <= RSEL_BYP;
                end else begin
                    rsel <= RSEL_RAM;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rsel)
            RSEL_RAM: rd_data = ram_q;
            RSEL_BYP: rd_data = byp_q;
            default:  rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_neuron_state_mem.sv
// Bench for neuron_state_mem: DEPTH=8 and DEPTH=6 instances share stimulus and are
// compared every cycle against a countdown-based behavioural model.
module tb_neuron_state_mem;

    localparam int DW = 32;
    localparam int AW = 3;

`ifdef BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          init_start = 1'b0;
    logic [DW-1:0] init_value = '0;
    logic          rd_en      = 1'b0;
    logic [AW-1:0] rd_addr    = '0;
    logic          wr_en      = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [DW-1:0] wr_data    = '0;

    logic [DW-1:0] rd_data8, rd_data6;
    logic          rd_valid8, rd_valid6;
    logic          busy8, busy6;
    logic          init_done8, init_done6;
    logic          access_drop8, access_drop6;

    always #5 clk = ~clk;

    neuron_state_mem #(.DATA_W(DW), .DEPTH(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .init_start  (init_start),
        .init_value  (init_value),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data8),
        .rd_valid    (rd_valid8),
        .busy        (busy8),
        .init_done   (init_done8),
        .access_drop (access_drop8)
    );

    neuron_state_mem #(.DATA_W(DW), .DEPTH(6)) u_dut6 (
        .clk         (clk),
        .reset       (reset),
        .init_start  (init_start),
        .init_value  (init_value),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data6),
        .rd_valid    (rd_valid6),
        .busy        (busy6),
        .init_done   (init_done6),
        .access_drop (access_drop6)
    );

    int total = 0;
    int bad   = 0;

    // Model: bcnt counts remaining busy cycles; the memory image is refreshed
    // wholesale when a sweep completes since partial sweeps are never observable.
    int            dep [2] = '{8, 6};
    int            bcnt [2];
    logic [DW-1:0] mmem [2][8];
    logic [DW-1:0] ireg [2];
    logic [DW-1:0] e_data [2];
    logic          e_valid [2];
    logic          e_done [2];
    logic          e_drop [2];
    int            seen_busy [2];
    int            seen_done [2];

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            bcnt[d]    = dep[d] + 1;
            e_data[d]  = '0;
            e_valid[d] = 1'b0;
            e_done[d]  = 1'b0;
            e_drop[d]  = 1'b0;
        end
    endtask

    task automatic modelStep();
        for (int d = 0; d < 2; d++) begin
            int depth_d;
            depth_d    = dep[d];
            e_done[d]  = 1'b0;
            e_drop[d]  = 1'b0;
            e_valid[d] = 1'b0;
            if (bcnt[d] > 0) begin
                e_drop[d] = rd_en | wr_en;
                if (init_start) begin
                    bcnt[d] = depth_d + 1;
                end else begin
                    if (bcnt[d] == depth_d + 1) ireg[d] = init_value;
                    bcnt[d]--;
                    if (bcnt[d] == 0) begin
                        for (int k = 0; k < depth_d; k++) mmem[d][k] = ireg[d];
                        e_done[d] = 1'b1;
                    end
                end
            end else begin
                if (rd_en) begin
                    e_valid[d] = 1'b1;
                    if (int'(rd_addr) >= depth_d) e_data[d] = '0;
                    else if (BYP && wr_en && (wr_addr == rd_addr)) e_data[d] = wr_data;
                    else e_data[d] = mmem[d][rd_addr];
                end
                if (wr_en && (int'(wr_addr) < depth_d)) mmem[d][wr_addr] = wr_data;
                if (init_start) bcnt[d] = depth_d + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        chk("d8_rd_data",     rd_data8,            e_data[0]);
        chk("d8_rd_valid",    DW'(rd_valid8),      DW'(e_valid[0]));
        chk("d8_busy",        DW'(busy8),          DW'(bcnt[0] > 0));
        chk("d8_init_done",   DW'(init_done8),     DW'(e_done[0]));
        chk("d8_access_drop", DW'(access_drop8),   DW'(e_drop[0]));
        chk("d6_rd_data",     rd_data6,            e_data[1]);
        chk("d6_rd_valid",    DW'(rd_valid6),      DW'(e_valid[1]));
        chk("d6_busy",        DW'(busy6),          DW'(bcnt[1] > 0));
        chk("d6_init_done",   DW'(init_done6),     DW'(e_done[1]));
        chk("d6_access_drop", DW'(access_drop6),   DW'(e_drop[1]));
        seen_busy[0] += int'(busy8);
        seen_busy[1] += int'(busy6);
        seen_done[0] += int'(init_done8);
        seen_done[1] += int'(init_done6);
    endtask

    task automatic applyStimulus(input logic re, input logic [AW-1:0] ra, input logic we,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic is);
        rd_en      = re;
        rd_addr    = ra;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        init_start = is;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic readAll();
        for (int a = 0; a < 8; a++) applyStimulus(1'b1, AW'(a), 1'b0, '0, '0, 1'b0);
        idleCycles(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [AW-1:0] ra;
        $display("[TB] start, bypass=%0d", BYP);
        init_value = 32'h0000_0400;
        modelReset();
        #2;
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b0;

        // Power-up sweep: busy for DEPTH+1 cycles, one init_done, words = 0x400
        seen_busy[0] = int'(busy8);
        seen_busy[1] = int'(busy6);
        seen_done    = '{0, 0};
        idleCycles(12);
        chk("t1_busy_cycles8", seen_busy[0], 9);
        chk("t1_busy_cycles6", seen_busy[1], 7);
        chk("t1_done_count8", seen_done[0], 1);
        chk("t1_done_count6", seen_done[1], 1);
        readAll();

        applyStimulus(1'b0, '0, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b1, 3'd3, 1'b0, '0, '0, 1'b0);
        chk("t2_rd_data", rd_data8, 32'hDEAD_BEEF);
        chk("t2_rd_valid", DW'(rd_valid8), 32'd1);

        applyStimulus(1'b1, 3'd5, 1'b1, 3'd5, 32'h0000_1234, 1'b0);
        chk("t3_same_cycle", rd_data8, BYP ? 32'h0000_1234 : 32'h0000_0400);
        applyStimulus(1'b1, 3'd5, 1'b0, '0, '0, 1'b0);
        chk("t3_next_read", rd_data8, 32'h0000_1234);

        // Restart the sweep when it has reached address 4
        init_value = 32'hAAAA_0000;
        seen_done  = '{0, 0};
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idleCycles(5);
        init_value = 32'h0000_0007;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idleCycles(1);
        init_value = $urandom;
        idleCycles(12);
        chk("t4_done_count8", seen_done[0], 1);
        chk("t4_done_count6", seen_done[1], 1);
        readAll();
        chk("t4_word7", rd_data8, 32'h0000_0007);

        // Accesses while busy are dropped
        init_value = 32'h5A5A_5A5A;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 3'd2, 1'b1, 3'd2, 32'h1111_2222, 1'b0);
        chk("t5_drop", DW'(access_drop8), 32'd1);
        chk("t5_no_valid", DW'(rd_valid8), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, AW'(i), 1'b1, AW'(i), $urandom, 1'b0);
        idleCycles(12);
        readAll();

        // Out-of-range address on the DEPTH=6 instance
        applyStimulus(1'b0, '0, 1'b1, 3'd7, 32'h0000_0055, 1'b0);
        applyStimulus(1'b1, 3'd7, 1'b0, '0, '0, 1'b0);
        chk("t6_oor_data", rd_data6, 32'h0);
        chk("t6_oor_valid", DW'(rd_valid6), 32'd1);
        readAll();

        // Asynchronous reset in the middle of a sweep
        init_value = 32'h0BAD_F00D;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idleCycles(3);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b0;
        idleCycles(12);
        readAll();

        // Random traffic with occasional re-initialisation
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) init_value = $urandom;
            ra = AW'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 7)),
                          $urandom, ($urandom_range(0, 59) == 0));
        end
        idleCycles(12);
        readAll();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
